// File: rtl/serpent_engine_arbiter.sv
// -----------------------------------------------------------------------------
// serpent_engine_arbiter
//
// Shares one Serpent-256 encrypt engine between two requesters. Port 0 carries
// the XTS tweak path, port 1 the XTS data path. Jobs are granted round-robin;
// for each job the block issues a one-cycle engine start, holds key/plaintext
// stable while the engine runs, captures the ciphertext on the done pulse and
// returns it to the granted port on a valid/ready response channel.
//
// Handshakes: a request on port n is accepted in the cycle where i_req_valid[n]
// and o_req_ready[n] are both high (o_req_ready is one-hot or zero, IDLE only).
// A response on port n completes in the cycle where o_rsp_valid[n] and
// i_rsp_ready[n] are both high; data/tag/err are held until then.
//
// Optional feature (macro SERPENT_ARB_TIMEOUT_EN): engine watchdog. If the
// engine does not signal done within TIMEOUT_CYCLES cycles of BUSY, the job
// completes with o_rsp_err=1 and zero data, and new starts are held off until
// a late done pulse arrives or 64 cycles pass. Without the macro, BUSY waits
// indefinitely and o_rsp_err is tied low.
//
// Ports:
//   i_clk, i_rstn                 clock, asynchronous active-low reset
//   i_req_valid / o_req_ready     per-port request handshake (bit n = port n)
//   i_req_key0/1, i_req_data0/1   256-bit key and 128-bit plaintext per port
//   i_req_tag0/1                  opaque per-port tag returned with response
//   o_rsp_valid / i_rsp_ready     per-port response handshake
//   o_rsp_data, o_rsp_tag         shared ciphertext and tag of the response
//   o_rsp_err                     1 = watchdog abort (data all zero)
//   o_eng_master_key_valid,
//   o_eng_enable                  one-cycle engine start qualifiers
//   o_eng_key, o_eng_data         engine key / plaintext, stable START..BUSY
//   i_eng_data, i_eng_data_valid  engine ciphertext and done pulse
//   o_busy                        high in every state except IDLE
//   o_dbg_state                   current FSM state (IDLE=0 START=1 BUSY=2 RESP=3)
// -----------------------------------------------------------------------------
module serpent_engine_arbiter #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [255:0]     i_req_key0,
    input  logic [255:0]     i_req_key1,
    input  logic [127:0]     i_req_data0,
    input  logic [127:0]     i_req_data1,
    input  logic [TAG_W-1:0] i_req_tag0,
    input  logic [TAG_W-1:0] i_req_tag1,
    output logic [1:0]       o_rsp_valid,
    input  logic [1:0]       i_rsp_ready,
    output logic [127:0]     o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_rsp_err,
    output logic             o_eng_master_key_valid,
    output logic             o_eng_enable,
    output logic [255:0]     o_eng_key,
    output logic [127:0]     o_eng_data,
    input  logic [127:0]     i_eng_data,
    input  logic             i_eng_data_valid,
    output logic             o_busy,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    if (TAG_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("serpent_engine_arbiter: TAG_W and TIMEOUT_CYCLES must be >= 1");
    end

    state_e             state_q, state_d;
    // grant_q doubles as the round-robin pointer: it always names the port
    // granted last. Reset value 1 makes port 0 win the first contention.
    logic               grant_q, grant_d;
    logic [255:0]       key_q;
    logic [127:0]       data_q;
    logic [TAG_W-1:0]   tag_q;
    logic [127:0]       rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

    logic               pick;
    logic               accept;
    logic               start_ok;
    logic               tmo_hit;
    logic [1:0]         req_ready;

    // Contention goes to the port that was not granted last.
    assign pick   = (i_req_valid == 2'b11) ? ~grant_q : i_req_valid[1];
    assign accept = (state_q == ST_IDLE) && (|i_req_valid) && start_ok;

    always_comb begin
        req_ready  = 2'b00;
        state_d    = state_q;
        grant_d    = grant_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready[pick] = 1'b1;
                    grant_d         = pick;
                    state_d         = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // A real done pulse wins over a watchdog expiry in the same cycle.
                if (i_eng_data_valid) begin
                    rsp_data_d = i_eng_data;
                    rsp_tag_d  = tag_q;
                    state_d    = ST_RESP;
                end else if (tmo_hit) begin
                    rsp_data_d = '0;
                    rsp_tag_d  = tag_q;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b1;
            key_q      <= '0;
            data_q     <= '0;
            tag_q      <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            if (accept) begin
                key_q  <= pick ? i_req_key1  : i_req_key0;
                data_q <= pick ? i_req_data1 : i_req_data0;
                tag_q  <= pick ? i_req_tag1  : i_req_tag0;
            end
        end
    end

`ifdef SERPENT_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             blk_q;
    logic [5:0]       blk_cnt_q;
    logic             rsp_err_q;

    // Counter is 0 in the first BUSY cycle, so expiry after TIMEOUT_CYCLES
    // BUSY cycles happens when it shows TIMEOUT_CYCLES-1.
    assign tmo_hit  = (state_q == ST_BUSY) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    // The engine was not reset on abort; keep it idle until it finishes the
    // abandoned job (late done) or the 64-cycle hold-off runs out.
    assign start_ok = !blk_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tmo_cnt_q <= '0;
            blk_q     <= 1'b0;
            blk_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (state_q == ST_START) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ST_BUSY) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            if (state_q == ST_BUSY) begin
                if (i_eng_data_valid) begin
                    rsp_err_q <= 1'b0;
                end else if (tmo_hit) begin
                    rsp_err_q <= 1'b1;
                end
            end

            if (tmo_hit && !i_eng_data_valid) begin
                blk_q     <= 1'b1;
                blk_cnt_q <= '0;
            end else if (blk_q) begin
                if (i_eng_data_valid || (blk_cnt_q == 6'd63)) begin
                    blk_q <= 1'b0;
                end else begin
                    blk_cnt_q <= blk_cnt_q + 1'b1;
                end
            end
        end
    end

    assign o_rsp_err = rsp_err_q;
`else
    assign tmo_hit   = 1'b0;
    assign start_ok  = 1'b1;
    assign o_rsp_err = 1'b0;
`endif

    // Ready is combinational from the IDLE grant; gating with i_rstn keeps it
    // low while reset is held even if requests are present.
    assign o_req_ready            = req_ready & {2{i_rstn}};
    assign o_rsp_valid            = (state_q == ST_RESP) ? {grant_q, ~grant_q} : 2'b00;
    assign o_rsp_data             = rsp_data_q;
    assign o_rsp_tag              = rsp_tag_q;
    assign o_eng_master_key_valid = (state_q == ST_START);
    assign o_eng_enable           = (state_q == ST_START);
    assign o_eng_key              = ((state_q == ST_START) || (state_q == ST_BUSY)) ? key_q  : '0;
    assign o_eng_data             = ((state_q == ST_START) || (state_q == ST_BUSY)) ? data_q : '0;
    assign o_busy                 = (state_q != ST_IDLE);
    assign o_dbg_state            = state_q;

endmodule

// File: doc/serpent_engine_arbiter.md
Name: serpent_engine_arbiter

Overview:
- Shares one Serpent-256 encrypt engine between two requesters, port 0 and port 1.
- Port 0 carries the XTS tweak path; port 1 carries the XTS data path.
- Round-robin arbitration; for each granted job the block drives the engine start handshake, holds key and data stable, captures the result and returns it to the granted port on a valid/ready response channel.
- Sits between the XTS sector sequencer and the full-key-schedule encrypt engine.

Parameters:
- TAG_W, 4, width of the opaque tag carried from request to response per port.
- TIMEOUT_CYCLES, 4095, engine watchdog limit in cycles; used only with SERPENT_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_req_valid  in  2  per-port request valid; bit n = port n
- o_req_ready  out  2  per-port request accepted this cycle (one-hot or zero)
- i_req_key0 / i_req_key1  in  256  master key, port 0 / port 1
- i_req_data0 / i_req_data1  in  128  plaintext block, port 0 / port 1
- i_req_tag0 / i_req_tag1  in  TAG_W  tag, port 0 / port 1
- o_rsp_valid  out  2  per-port response valid
- i_rsp_ready  in  2  per-port response ready
- o_rsp_data  out  128  ciphertext, shared by both ports; qualified by o_rsp_valid
- o_rsp_tag  out  TAG_W  tag of the current response
- o_rsp_err  out  1  1 = timeout abort; o_rsp_data is all zero
- o_eng_master_key_valid  out  1  engine start qualifier
- o_eng_enable  out  1  engine start qualifier
- o_eng_key  out  256  engine key
- o_eng_data  out  128  engine plaintext
- i_eng_data  in  128  engine ciphertext
- i_eng_data_valid  in  1  engine done pulse
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE, round-robin pointer = 1 (port 0 wins the first contention), o_req_ready=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_tag=0, o_rsp_err=0, o_eng_* = 0, o_busy=0.
- Reset mid-job abandons the job with no response; all outputs return to reset values immediately.
- IDLE
  - Requesters present: if exactly one port has valid, grant it.
  - Both valid: grant the port that is not the round-robin pointer.
  - In the grant cycle, o_req_ready[grant]=1 for exactly one cycle; key, data and tag are registered into internal holding registers; pointer := grant; next state START.
  - Requests are never accepted outside IDLE.
- START (1 cycle)
  - o_eng_master_key_valid=1 and o_eng_enable=1 for exactly this cycle.
  - o_eng_key and o_eng_data are driven from the holding registers.
  - Next state BUSY.
- BUSY
  - o_eng_key and o_eng_data stay stable; the start qualifiers are 0.
  - On i_eng_data_valid=1: capture i_eng_data into o_rsp_data, set o_rsp_tag from the held tag, o_rsp_err=0; next state RESP.
- RESP
  - o_rsp_valid[grant]=1; data, tag and err are held until i_rsp_ready[grant]=1. That cycle is the last cycle of o_rsp_valid; next state IDLE.
  - i_rsp_ready on the non-granted port is ignored.
  - o_eng_key and o_eng_data return to 0 on RESP entry.
- Minimum spacing: the next engine start can occur no earlier than 3 cycles after the done pulse (RESP, IDLE grant, START). This guarantees the engine has returned to its idle state before restart.
- Latency: request accept to engine start = 1 cycle; done pulse to o_rsp_valid = 1 cycle.
- A done pulse outside BUSY is ignored.
- Every job is sent through the engine, including a repeated key; the engine runs its key schedule on every job.

Optional Feature:
- SERPENT_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on START and increments in BUSY.
  - If the counter reaches TIMEOUT_CYCLES without a done pulse: enter RESP with o_rsp_err=1, o_rsp_data=0, tag preserved.
  - The engine is not reset; all starts are blocked until a further done pulse arrives or 64 cycles elapse, whichever comes first.
- SERPENT_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; o_rsp_err is tied to 0.

Test Plan:
- Port 0 only, key 256'h0, data 128'h0, tag 4'h3; engine model returns 128'h8910494504181950F98DD998A82B6749 after 40 cycles -> one START pulse, o_rsp_valid=2'b01 one cycle after done, data matches, tag=3, err=0.
- Both ports valid from reset -> grants in order port 0, 1, 0, 1 over four jobs; o_req_ready is never 2'b11.
- Port 1 response with i_rsp_ready held low for 10 cycles -> data, tag and valid stable for all 10 cycles; port 0 request is not accepted until the cycle after the handshake.
- i_rstn asserted in BUSY -> all outputs go to 0 asynchronously; after release the pending port 0 is granted first.
- SERPENT_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, engine never done -> o_rsp_err=1, o_rsp_data=0 in RESP, tag preserved; next start blocked for 64 cycles.
- Spurious i_eng_data_valid in IDLE -> no response, state unchanged.
